// File: rtl/pc_gen.sv
// PC generation stage: holds the fetch PC, follows the predictor, and applies
// execute redirects without ever moving the address of an outstanding ibus request.
module pc_gen #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_wait,
    input  logic [63:0] predPC,
    input  logic        stallF,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] pc,
    output logic        kill_F,
    output logic        redirect_pending
);

    typedef enum logic {
        RUN,
        WAIT_REDIR
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_pend_pc;

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; the async reset sits in the sensitivity list.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RUN;
            r_pc      <= RESET_PC;
            r_pend_pc <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (redirect_valid && !imem_wait) begin
                        r_pc <= redirect_pc;
                    end else if (redirect_valid) begin
                        // Bus busy: park the target until the in-flight request returns.
                        r_pend_pc <= redirect_pc;
                        r_state   <= WAIT_REDIR;
                    end else if (!imem_wait && !stallF) begin
                        r_pc <= predPC;
                    end
                end
                WAIT_REDIR: begin
                    if (redirect_valid) begin
                        r_pend_pc <= redirect_pc;
                    end
                    if (!imem_wait) begin
                        r_pc    <= redirect_valid ? redirect_pc : r_pend_pc;
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign pc               = r_pc;
    assign redirect_pending = (r_state == WAIT_REDIR);
    assign kill_F           = !reset && (redirect_valid || (r_state == WAIT_REDIR));

endmodule
